// File: rtl/vlan_act_cls_pkg.sv
// Shared constants for the VLAN action pipe: op codes, packet-type codes, ethertypes
// and the op-legality rule applied on the SOP beat.
package vlan_act_cls_pkg;

  localparam int OP_W = 2;
  localparam int PT_W = 4;

  localparam logic [OP_W-1:0] VLAN_OP_NOP    = 2'b00;
  localparam logic [OP_W-1:0] VLAN_OP_INSERT = 2'b01;
  localparam logic [OP_W-1:0] VLAN_OP_MODIFY = 2'b11;
  localparam logic [OP_W-1:0] VLAN_OP_REMOVE = 2'b10;

  localparam logic [PT_W-1:0] PT_OTHER = 4'd0;
  localparam logic [PT_W-1:0] PT_IPV4  = 4'd1;
  localparam logic [PT_W-1:0] PT_VLV4  = 4'd2;
  localparam logic [PT_W-1:0] PT_IPV6  = 4'd3;
  localparam logic [PT_W-1:0] PT_VLV6  = 4'd4;

  localparam logic [15:0] ET_IPV4 = 16'h0800;
  localparam logic [15:0] ET_IPV6 = 16'h86DD;
  localparam logic [15:0] ET_VLAN = 16'h8100;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } frame_state_e;

  // Untagged frames may only gain a tag; tagged frames may only have theirs edited or stripped.
  function automatic logic [OP_W-1:0] legal_op(input logic [OP_W-1:0] op, input logic [PT_W-1:0] pt);
    logic [OP_W-1:0] res;
    case (pt)
      PT_IPV4, PT_IPV6: res = (op == VLAN_OP_INSERT) ? op : VLAN_OP_NOP;
      PT_VLV4, PT_VLV6: res = (op == VLAN_OP_INSERT) ? VLAN_OP_NOP : op;
      default:          res = VLAN_OP_NOP;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/vlan_act_cls_pkt_type_dec.sv
// Combinational ethertype classifier: outer ethertype (et0) and the ethertype
// following a single 802.1Q tag (et1) map to a packet-type code.
module pkt_type_dec
  import vlan_act_cls_pkg::*;
(
  input  logic [15:0]     et0,
  input  logic [15:0]     et1,
  output logic [PT_W-1:0] pkt_type
);

  // Ethertype decode
  always_comb begin
    pkt_type = PT_OTHER;
    if (et0 == ET_IPV4) begin
      pkt_type = PT_IPV4;
    end else if (et0 == ET_IPV6) begin
      pkt_type = PT_IPV6;
    end else if (et0 == ET_VLAN && et1 == ET_IPV4) begin
      pkt_type = PT_VLV4;
    end else if (et0 == ET_VLAN && et1 == ET_IPV6) begin
      pkt_type = PT_VLV6;
    end else begin
      pkt_type = PT_OTHER;
    end
  end

endmodule

// File: rtl/vlan_act_cls.sv
// Classifies each packet on its SOP beat, joins it with the lookup's action word and
// emits the stream through one register slice with beat-aligned VLAN sideband.
module vlan_act_cls
  import vlan_act_cls_pkg::*;
#(
  parameter int DATA_WIDTH    = 512,
  parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH/8),
  parameter int CHANNEL_WIDTH = 6,
  parameter int ERROR_WIDTH   = 4,
  parameter int VLAN_OP_WIDTH = OP_W,
  parameter int VLAN_WIDTH    = 16,
  parameter int PT_WIDTH      = PT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     act_valid,
  output logic                     act_ready,
  input  logic [VLAN_OP_WIDTH-1:0] act_vlan_op,
  input  logic [VLAN_WIDTH-1:0]    act_vlan_data,
  input  logic [DATA_WIDTH-1:0]    stream_in_data,
  input  logic [EMPTY_WIDTH-1:0]   stream_in_empty,
  input  logic                     stream_in_valid,
  input  logic                     stream_in_startofpacket,
  input  logic                     stream_in_endofpacket,
  input  logic [CHANNEL_WIDTH-1:0] stream_in_channel,
  input  logic [ERROR_WIDTH-1:0]   stream_in_error,
  output logic                     stream_in_ready,
  output logic [DATA_WIDTH-1:0]    stream_out_data,
  output logic [EMPTY_WIDTH-1:0]   stream_out_empty,
  output logic                     stream_out_valid,
  output logic                     stream_out_startofpacket,
  output logic                     stream_out_endofpacket,
  output logic [CHANNEL_WIDTH-1:0] stream_out_channel,
  output logic [ERROR_WIDTH-1:0]   stream_out_error,
  input  logic                     stream_out_ready,
  output logic [VLAN_OP_WIDTH-1:0] vlan_op,
  output logic [VLAN_WIDTH-1:0]    vlan_data,
  output logic [PT_WIDTH-1:0]      pkt_type,
  output logic [31:0]              stat_pkt_cnt,
  output logic [15:0]              stat_err_cnt
);

  frame_state_e             state_q, state_d;
  logic                     run_q;
  logic                     valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [EMPTY_WIDTH-1:0]   empty_q, empty_d;
  logic [CHANNEL_WIDTH-1:0] chan_q, chan_d;
  logic [ERROR_WIDTH-1:0]   err_q, err_d;
  logic [VLAN_OP_WIDTH-1:0] op_q, op_d;
  logic [VLAN_WIDTH-1:0]    vdata_q, vdata_d, hold_vdata_q, hold_vdata_d;
  logic [PT_WIDTH-1:0]      pt_q, pt_d, hold_pt_q, hold_pt_d;
  logic [31:0]              pkt_cnt_q, pkt_cnt_d;
  logic [15:0]              err_cnt_q, err_cnt_d;

  logic            slot_free_s, in_ready_s, accept_s, orphan_s, fwd_s, resync_s;
  logic [PT_W-1:0] cls_pt_s;

  pkt_type_dec u_pkt_type_dec (
    .et0      (stream_in_data[DATA_WIDTH-97 -: 16]),
    .et1      (stream_in_data[DATA_WIDTH-129 -: 16]),
    .pkt_type (cls_pt_s)
  );

  // run_q keeps both ready outputs low while and right after reset is asserted
  assign slot_free_s     = !valid_q || stream_out_ready;
  assign in_ready_s      = run_q && slot_free_s && (!stream_in_startofpacket || act_valid);
  assign stream_in_ready = in_ready_s;
  assign act_ready       = run_q && stream_in_valid && stream_in_startofpacket && slot_free_s && act_valid;
  assign accept_s        = stream_in_valid && in_ready_s;
  assign orphan_s        = accept_s && !stream_in_startofpacket && (state_q == ST_IDLE);
  assign resync_s        = accept_s && stream_in_startofpacket && (state_q == ST_IN_PKT);
  assign fwd_s           = accept_s && !orphan_s;

  // Next-state for the output slice, frame tracker and statistics
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q && !stream_out_ready;
    sop_d        = sop_q;
    eop_d        = eop_q;
    data_d       = data_q;
    empty_d      = empty_q;
    chan_d       = chan_q;
    err_d        = err_q;
    op_d         = op_q;
    vdata_d      = vdata_q;
    pt_d         = pt_q;
    hold_vdata_d = hold_vdata_q;
    hold_pt_d    = hold_pt_q;
    pkt_cnt_d    = pkt_cnt_q;
    err_cnt_d    = err_cnt_q;

    if (fwd_s) begin
      valid_d = 1'b1;
      sop_d   = stream_in_startofpacket;
      eop_d   = stream_in_endofpacket;
      data_d  = stream_in_data;
      empty_d = stream_in_empty;
      chan_d  = stream_in_channel;
      err_d   = stream_in_error;
      if (stream_in_startofpacket) begin
        op_d         = legal_op(act_vlan_op, cls_pt_s);
        vdata_d      = act_vlan_data;
        pt_d         = cls_pt_s;
        hold_vdata_d = act_vlan_data;
        hold_pt_d    = cls_pt_s;
        pkt_cnt_d    = pkt_cnt_q + 32'd1;
        state_d      = stream_in_endofpacket ? ST_IDLE : ST_IN_PKT;
      end else begin
        op_d    = VLAN_OP_NOP;
        vdata_d = hold_vdata_q;
        pt_d    = hold_pt_q;
        state_d = stream_in_endofpacket ? ST_IDLE : ST_IN_PKT;
      end
    end else begin
      state_d = state_q;
    end

    if ((orphan_s || resync_s) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      run_q        <= 1'b0;
      valid_q      <= 1'b0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      data_q       <= '0;
      empty_q      <= '0;
      chan_q       <= '0;
      err_q        <= '0;
      op_q         <= '0;
      vdata_q      <= '0;
      pt_q         <= '0;
      hold_vdata_q <= '0;
      hold_pt_q    <= '0;
      pkt_cnt_q    <= 32'd0;
      err_cnt_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      run_q        <= 1'b1;
      valid_q      <= valid_d;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
      data_q       <= data_d;
      empty_q      <= empty_d;
      chan_q       <= chan_d;
      err_q        <= err_d;
      op_q         <= op_d;
      vdata_q      <= vdata_d;
      pt_q         <= pt_d;
      hold_vdata_q <= hold_vdata_d;
      hold_pt_q    <= hold_pt_d;
      pkt_cnt_q    <= pkt_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign stream_out_data          = data_q;
  assign stream_out_empty         = empty_q;
  assign stream_out_valid         = valid_q;
  assign stream_out_startofpacket = sop_q;
  assign stream_out_endofpacket   = eop_q;
  assign stream_out_channel       = chan_q;
  assign stream_out_error         = err_q;
  assign vlan_op                  = op_q;
  assign vlan_data                = vdata_q;
  assign pkt_type                 = pt_q;
  assign stat_pkt_cnt             = pkt_cnt_q;
  assign stat_err_cnt             = err_cnt_q;

endmodule
